// File: rtl/ram_req_ctrl_if.sv
// Request/response handshake channel between a RAM client and ram_req_ctrl.
// The master issues requests and consumes read data; the slave is the controller.
interface ram_req_ctrl_if #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/ram_req_ctrl.sv
// Handshake front end for a single-port sync RAM (posedge write, negedge fetch).
// Define RAM_REQ_CTRL_RSP_BP_EN to hold read responses until rsp_ready.
module ram_req_ctrl #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_req_ctrl_if.slave         bus,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
`ifdef RAM_REQ_CTRL_RSP_BP_EN
    RD   = 2'd2,
    RSP  = 2'd3
`else
    RD   = 2'd2
`endif
  } state_t;

  state_t                state;
  state_t                next_state;
  logic                  accept;
  logic                  drive_en;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  assign accept        = bus.req_valid && req_ready_q;
  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign ram_addr      = addr_q;

  // The bus is only ours during WR; everywhere else the RAM may own it.
  assign ram_data = drive_en ? wdata_q : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    ram_cs     = 1'b0;
    ram_we     = 1'b0;
    ram_oe     = 1'b0;
    drive_en   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = bus.req_we ? WR : RD;
        end
      end
      WR: begin
        ram_cs     = 1'b1;
        ram_we     = 1'b1;
        drive_en   = 1'b1;
        next_state = IDLE;
      end
      RD: begin
        ram_cs = 1'b1;
        ram_oe = 1'b1;
`ifdef RAM_REQ_CTRL_RSP_BP_EN
        next_state = RSP;
`else
        next_state = IDLE;
`endif
      end
`ifdef RAM_REQ_CTRL_RSP_BP_EN
      RSP: begin
        if (bus.rsp_ready) begin
          next_state = IDLE;
        end
      end
`endif
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Ready is registered from the next state, so an accept is never back-to-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      req_ready_q <= (next_state == IDLE);
      if (accept) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (state == RD) begin
        rsp_rdata_q <= ram_data;
      end
`ifdef RAM_REQ_CTRL_RSP_BP_EN
      if (state == RD) begin
        rsp_valid_q <= 1'b1;
      end else if ((state == RSP) && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
`else
      rsp_valid_q <= (state == RD);
`endif
    end
  end

`ifndef RAM_REQ_CTRL_RSP_BP_EN
  logic unused_rsp_ready;
  assign unused_rsp_ready = bus.rsp_ready;
`endif

endmodule

// File: doc/ram_req_ctrl.md
# ram_req_ctrl

Request-side controller that sits directly upstream of the single-port synchronous RAM. It accepts read/write requests over a valid/ready handshake and drives the RAM's address, data, and control strobes (cs/we/oe). It also manages the RAM's shared tri-state data bus and returns read data over a response channel. This gives the rest of the design a clean handshake view of a RAM that writes on posedge and fetches on negedge.

## Interface
- ADDR_WIDTH, 28, RAM word-address width
- DATA_WIDTH, 16, RAM word width

- clk  in  1  single clock; all state on posedge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  read data valid
- rsp_ready  in  1  consumer accepts read data (used only with RAM_REQ_CTRL_RSP_BP_EN)
- rsp_rdata  out  DATA_WIDTH  read data
- ram_addr  out  ADDR_WIDTH  to RAM addr
- ram_data  inout  DATA_WIDTH  shared RAM data bus
- ram_cs  out  1  RAM chip select
- ram_we  out  1  RAM write enable
- ram_oe  out  1  RAM output enable

## Operation
- **FSM states:** IDLE, WR, RD, RSP. RSP exists only with the macro.
- **Accept:** a request is accepted on a posedge where req_valid && req_ready. At that edge:
  - req_we, req_addr, and req_wdata are registered.
  - The FSM goes to WR if req_we=1, otherwise RD.
- **IDLE:**
  - ram_cs=0, ram_we=0, ram_oe=0.
  - ram_data is Z.
- **WR (1 cycle):**
  - ram_cs=1, ram_we=1, ram_oe=0.
  - ram_addr and ram_data carry the registered address and data.
  - The RAM commits at the posedge that ends WR.
  - Next state is IDLE.
- **RD (1 cycle):**
  - ram_cs=1, ram_we=0, ram_oe=1.
  - ram_data is Z, so the RAM drives it after its negedge fetch.
  - At the posedge ending RD, rsp_rdata <= ram_data and rsp_valid <= 1.
  - Next state is IDLE, or RSP with the macro.
- **Bus ownership:** the controller drives ram_data only while in WR. There is never a cycle where both the controller and the RAM drive the bus.
- **req_ready:** registered; equals 1 exactly when the next state is IDLE. There are no back-to-back accepts, so throughput is one request per 2 cycles.
- **rsp_rdata:** holds its last value until the next read completes.
- **req_valid while req_ready=0:** ignored; the request is not latched.

## Timing
- **Reset values:**
  - State IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0.
  - ram_cs=0, ram_we=0, ram_oe=0, ram_addr=0, ram_data=Z.
- **After reset release:** req_ready rises at the first posedge with rst_n=1.
- **Write accepted at edge E0:**
  - WR occupies cycle E0..E1.
  - Memory is updated at E1.
  - req_ready=1 after E1.
- **Read accepted at edge E0:**
  - RD occupies cycle E0..E1.
  - rsp_valid=1 and rsp_rdata valid after E1, i.e. 1-cycle latency from accept to response.
- **Reset mid-operation:** rst_n low immediately forces ram_cs=0, ram_we=0, ram_oe=0 and ram_data to Z.
  - An in-flight write is dropped; the memory is not written.
  - An in-flight read produces no response.
- **Read after write to the same address:** the write commits at E1; a read accepted at E2 returns the new data.
- **Address wrap-around:** none; addresses pass through unchanged.

## Configuration
- **RAM_REQ_CTRL_RSP_BP_EN defined** (response backpressure enabled):
  - After RD the FSM enters RSP.
  - rsp_valid and rsp_rdata hold stable until a posedge with rsp_ready=1, then the FSM returns to IDLE.
  - req_ready=0 throughout RSP.
  - If rsp_ready=1 already in the first RSP cycle, RSP lasts exactly 1 cycle.
- **RAM_REQ_CTRL_RSP_BP_EN undefined:**
  - rsp_valid is a 1-cycle pulse, asserted in the cycle after RD.
  - The FSM is in IDLE during that cycle, so req_ready=1 in parallel.
  - rsp_ready is ignored.

## Test plan
- **Reset:** hold rst_n=0 for 3 cycles, then release.
  - Expect req_ready=0 during reset and 1 after the first posedge with rst_n high.
  - Expect ram_cs=0 and ram_data=Z throughout reset.
- **Write then read:** write 0xBEEF to address 0x0000010, then read 0x0000010.
  - Expect ram_we=1 for exactly 1 cycle.
  - Expect rsp_rdata=0xBEEF with rsp_valid 1 cycle after the read accept.
- **Bus contention check:** run alternating writes and reads to addresses 0..15 with data = addr ^ 0xA5A5.
  - Expect every read to return the matching value.
  - Expect ram_data to be controller-driven only while ram_we=1.
- **Reset during WR:** assert rst_n low mid-cycle during a write of 0x1234 to address 5, where address 5 previously held 0x0000.
  - Expect a later read of address 5 to return 0x0000.
- **Backpressure (macro defined):** issue a read with rsp_ready=0 for 4 cycles.
  - Expect rsp_valid and rsp_rdata stable for those 4 cycles and req_ready=0.
  - Raise rsp_ready; expect rsp_valid=0 and req_ready=1 after that edge.
- **No backpressure (macro undefined):** issue a read with rsp_ready=0.
  - Expect a 1-cycle rsp_valid pulse and req_ready=1 in the same cycle.
